fft_frame_scheduler: RTL and testbench
======================================

# fft_frame_scheduler

Round-robin frame scheduler that shares one streaming variable-size FFT core among NCH requesting channels. It grants the core to one channel per frame and generates the core's sop/eop framing from the channel's requested size. It also drives the core's fftpts_in and inverse controls. Output frames are tagged with the originating channel ID. The block sits between the per-channel sample sources and the FFT core's Avalon-ST sink/source ports.

## Interface
Parameters:
- NCH, 4, number of requesting channels (2..8)
- DW, 16, input sample width per component
- OW, 20, output sample width per component
- TAG_DEPTH, 4, max frames in flight inside the core (power of two)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NCH  per-channel sample valid
- req_ready  out  NCH  per-channel sample accept
- req_real, req_imag  in  NCH*DW each  packed channel samples; channel i occupies bits [i*DW +: DW]
- req_fftpts  in  NCH*4  per-channel log2 frame size; sampled at grant
- req_inverse  in  NCH  per-channel inverse flag; sampled at grant
- fft_sink_valid, fft_sink_sop, fft_sink_eop  out  1 each  to core sink
- fft_sink_ready  in  1  core sink ready
- fft_sink_real, fft_sink_imag  out  DW each  muxed sample
- fft_sink_error  out  2  constant 2'b00
- fft_fftpts_in  out  4  latched frame size
- fft_inverse  out  1  latched inverse flag
- fft_source_valid, fft_source_sop, fft_source_eop  in  1 each  from core source
- fft_source_error  in  2  core error
- fft_source_real, fft_source_imag  in  OW each  core output
- fft_source_ready  out  1  equal to out_ready
- out_valid, out_sop, out_eop  out  1 each  combinational pass-through of the fft_source_* equivalents
- out_error  out  2  pass-through of fft_source_error
- out_real, out_imag  out  OW each  pass-through of fft_source_real/imag
- out_chan  out  clog2(NCH)  channel tag at the head of the tag FIFO
- out_ready  in  1  downstream ready
- busy  out  1  high in XFER
- inflight  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy

## Operation
- States: IDLE and XFER.
- IDLE: the block grants when any req_valid bit is set and inflight < TAG_DEPTH.
  - Grant goes to the first requesting channel at or after rr_ptr, wrapping modulo NCH.
  - On grant, register g, latch req_fftpts[g] into fft_fftpts_in and req_inverse[g] into fft_inverse, push g into the tag FIFO, clear sample counter cnt, and go to XFER.
- Frame length is N = 1 << fftpts, with legal fftpts 3..10. Values <3 are treated as 3 and values >10 as 10; fft_fftpts_in carries the clamped value.
- XFER datapath:
  - fft_sink_valid = req_valid[g].
  - req_ready[g] = fft_sink_ready. All other req_ready bits are 0.
  - fft_sink_real/imag are muxed from channel g, combinationally.
- XFER framing:
  - A handshake is fft_sink_valid & fft_sink_ready; each handshake increments cnt.
  - fft_sink_sop = (cnt == 0). fft_sink_eop = (cnt == N-1).
- Frame end: the handshake with eop returns the block to IDLE and sets rr_ptr = (g+1) mod NCH.
- fft_fftpts_in and fft_inverse hold their values from grant until the next grant.
- Gaps: deasserting req_valid[g] mid-frame only stalls the frame. The grant is held until eop is accepted; there is no timeout.
- Tag pop: the tag FIFO pops on fft_source_valid & out_ready & fft_source_eop.
- Simultaneous push and pop leaves inflight unchanged. The full check uses inflight before the same-cycle pop.
- Empty FIFO: out_chan = 0. If source data arrives with the FIFO empty, it is still passed through.
- Output path: no buffering, zero latency.

## Timing
- Reset (asynchronous, immediate) sets:
  - state IDLE, rr_ptr 0, g 0, cnt 0, tag FIFO empty, inflight 0, busy 0
  - fft_fftpts_in 0, fft_inverse 0
  - req_ready all 0, fft_sink_valid/sop/eop 0
- Grant latency: req_valid seen in IDLE in cycle t puts the block in XFER at t+1. The first sample can be accepted at t+1.
- Back-to-back frames: one IDLE cycle between the eop handshake and the next frame's sop, so minimum overhead is 1 cycle per frame.
- Reset asserted mid-frame abandons the frame. No eop is sent, and the core is expected to be reset by the same reset_n.
- In IDLE, fft_sink_valid is always 0.

## Test plan
- Single channel: ch0 streams 8 samples with fftpts=3 and ready held high. Expect sop on sample 0 and eop on sample 7, fft_fftpts_in=3, and one IDLE cycle before the next sop.
- Round-robin: ch0, ch1 and ch3 request continuously. Expect grant order 0, 1, 3, 0, with rr_ptr wrapping from 3 to 0 and each grant spanning a full frame.
- Backpressure and gaps: drop fft_sink_ready and req_valid randomly during a 16-point frame. Expect exactly 16 handshakes and eop only on the 16th.
- Tag FIFO full: set TAG_DEPTH=4 and hold out_ready low after 4 frames have been granted. Expect no 5th grant and inflight=4. A single output eop accepted while a channel is requesting gives a grant in the next cycle. out_chan tracks grant order.
- Clamp and inverse: ch2 requests with fftpts=15 and inverse=1. Expect fft_fftpts_in=10, a 1024-sample frame, fft_inverse=1 held through eop, and out_chan=2 on the output frame.
- Reset mid-frame: assert reset_n low at sample 5. Expect all outputs at reset values immediately. The next frame after release starts with sop from ch0.

Source files
------------

// File: rtl/fft_frame_scheduler_if.sv
// Bundle of channel-side, FFT-core-side and downstream signals around fft_frame_scheduler.
// The master modport is the scheduler's view. The slave modport is the surrounding system's view.
interface fft_frame_scheduler_if #(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int OW        = 20,
  parameter int TAG_DEPTH = 4
);
  localparam int CW = $clog2(NCH);
  localparam int IW = $clog2(TAG_DEPTH) + 1;

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*DW-1:0] req_real;
  logic [NCH*DW-1:0] req_imag;
  logic [NCH*4-1:0]  req_fftpts;
  logic [NCH-1:0]    req_inverse;

  logic              fft_sink_valid;
  logic              fft_sink_sop;
  logic              fft_sink_eop;
  logic              fft_sink_ready;
  logic [DW-1:0]     fft_sink_real;
  logic [DW-1:0]     fft_sink_imag;
  logic [1:0]        fft_sink_error;
  logic [3:0]        fft_fftpts_in;
  logic              fft_inverse;

  logic              fft_source_valid;
  logic              fft_source_sop;
  logic              fft_source_eop;
  logic [1:0]        fft_source_error;
  logic [OW-1:0]     fft_source_real;
  logic [OW-1:0]     fft_source_imag;
  logic              fft_source_ready;

  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [1:0]        out_error;
  logic [OW-1:0]     out_real;
  logic [OW-1:0]     out_imag;
  logic [CW-1:0]     out_chan;
  logic              out_ready;

  logic              busy;
  logic [IW-1:0]     inflight;

  modport master (
    input  req_valid, req_real, req_imag, req_fftpts, req_inverse,
    output req_ready,
    output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
    output fft_sink_error, fft_fftpts_in, fft_inverse,
    input  fft_sink_ready,
    input  fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    input  fft_source_real, fft_source_imag,
    output fft_source_ready,
    output out_valid, out_sop, out_eop, out_error, out_real, out_imag, out_chan,
    input  out_ready,
    output busy, inflight
  );

  modport slave (
    output req_valid, req_real, req_imag, req_fftpts, req_inverse,
    input  req_ready,
    input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
    input  fft_sink_error, fft_fftpts_in, fft_inverse,
    output fft_sink_ready,
    output fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
    output fft_source_real, fft_source_imag,
    input  fft_source_ready,
    input  out_valid, out_sop, out_eop, out_error, out_real, out_imag, out_chan,
    output out_ready,
    input  busy, inflight
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Round-robin scheduler that shares one variable-size streaming FFT core among NCH channels.
// It frames each granted channel's samples with sop/eop and tags the core's output frames with the originating channel.
module fft_frame_scheduler #(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int OW        = 20,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fft_frame_scheduler_if.master  bus
);
  localparam int CW = $clog2(NCH);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int IW = AW + 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rr_ptr_q, g_q, grant_idx;
  logic [9:0]    cnt_q;
  logic [3:0]    pts_q, pts_sel, pts_clamped;
  logic          inv_q;
  logic [CW-1:0] tag_mem_q [TAG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IW-1:0] inflight_q;
  logic          grant_found, grant, hs, last, pop;

  // Search for the first requester at or after rr_ptr, wrapping modulo NCH.
  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && bus.req_valid[(int'(rr_ptr_q) + i) % NCH]) begin
        grant_found = 1'b1;
        grant_idx   = CW'((int'(rr_ptr_q) + i) % NCH);
      end
    end
  end

  assign pts_sel     = bus.req_fftpts[grant_idx*4 +: 4];
  assign pts_clamped = (pts_sel < 4'd3) ? 4'd3 : (pts_sel > 4'd10) ? 4'd10 : pts_sel;

  // The full check uses occupancy before any same-cycle pop.
  assign grant = (state_q == IDLE) && grant_found && (inflight_q < IW'(TAG_DEPTH));
  assign hs    = (state_q == XFER) && bus.req_valid[g_q] && bus.fft_sink_ready;
  assign last  = (cnt_q == 10'((11'd1 << pts_q) - 11'd1));
  assign pop   = bus.fft_source_valid && bus.out_ready && bus.fft_source_eop && (inflight_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)       state_d = XFER;
      XFER:    if (hs && last)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = '0;
    bus.fft_sink_valid = 1'b0;
    bus.fft_sink_sop   = 1'b0;
    bus.fft_sink_eop   = 1'b0;
    bus.fft_sink_real  = bus.req_real[g_q*DW +: DW];
    bus.fft_sink_imag  = bus.req_imag[g_q*DW +: DW];
    if (state_q == XFER) begin
      bus.fft_sink_valid = bus.req_valid[g_q];
      bus.req_ready[g_q] = bus.fft_sink_ready;
      bus.fft_sink_sop   = (cnt_q == '0);
      bus.fft_sink_eop   = last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      g_q      <= '0;
      cnt_q    <= '0;
      pts_q    <= '0;
      inv_q    <= 1'b0;
    end else if (grant) begin
      g_q   <= grant_idx;
      pts_q <= pts_clamped;
      inv_q <= bus.req_inverse[grant_idx];
      cnt_q <= '0;
    end else if (hs) begin
      if (last) begin
        cnt_q    <= '0;
        rr_ptr_q <= (g_q == CW'(NCH - 1)) ? '0 : g_q + CW'(1);
      end else begin
        cnt_q <= cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
    end else begin
      if (grant) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({grant, pop})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // NOTE: tag storage has no reset; the pointers and occupancy alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (grant) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign bus.fft_sink_error   = 2'b00;
  assign bus.fft_fftpts_in    = pts_q;
  assign bus.fft_inverse      = inv_q;
  assign bus.fft_source_ready = bus.out_ready;
  assign bus.out_valid        = bus.fft_source_valid;
  assign bus.out_sop          = bus.fft_source_sop;
  assign bus.out_eop          = bus.fft_source_eop;
  assign bus.out_error        = bus.fft_source_error;
  assign bus.out_real         = bus.fft_source_real;
  assign bus.out_imag         = bus.fft_source_imag;
  assign bus.out_chan         = (inflight_q == '0) ? '0 : tag_mem_q[rd_ptr_q];
  assign bus.busy             = (state_q == XFER);
  assign bus.inflight         = inflight_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: framing, round-robin order, backpressure, tag FIFO limits, clamping and reset.
// The bench itself plays the role of the channels, the FFT core and the downstream consumer.
module tb_fft_frame_scheduler;
  localparam int NCH = 4, DW = 16, OW = 20, TAG_DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  fft_frame_scheduler_if #(.NCH(NCH), .DW(DW), .OW(OW), .TAG_DEPTH(TAG_DEPTH)) bus ();

  fft_frame_scheduler #(.NCH(NCH), .DW(DW), .OW(OW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE with a request pending; returns in the IDLE cycle after the eop handshake.
  task automatic frame(input int ch, input int n, input int exp_pts, input bit exp_inv, input bit rnd);
    int  k;
    bit  done;
    k    = 0;
    done = 1'b0;
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_sink_valid", bus.fft_sink_valid, 0);
    tick();
    check("grant_busy", bus.busy, 1);
    check("grant_fftpts", bus.fft_fftpts_in, exp_pts);
    check("grant_inverse", bus.fft_inverse, exp_inv);
    for (int c = 0; c < n * 4 + 64 && !done; c++) begin
      if (rnd) begin
        bus.fft_sink_ready = ($urandom_range(0, 3) != 0);
        bus.req_valid[ch]  = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (bus.fft_sink_valid && bus.fft_sink_ready) begin
        if (k == 0) begin
          check("first_real", bus.fft_sink_real, 32'(16'hA000 + ch));
          check("first_imag", bus.fft_sink_imag, 32'(16'h5000 + ch));
          check("first_req_ready", bus.req_ready, 32'(1 << ch));
        end
        check("sop_eop", {bus.fft_sink_sop, bus.fft_sink_eop}, {(k == 0), (k == n - 1)});
        if (bus.fft_sink_eop) done = 1'b1;
        k++;
      end
      tick();
    end
    check("frame_len", k, n);
    check("end_busy", bus.busy, 0);
    check("held_fftpts", bus.fft_fftpts_in, exp_pts);
    check("held_inverse", bus.fft_inverse, exp_inv);
    if (rnd) begin
      bus.fft_sink_ready = 1'b1;
      bus.req_valid[ch]  = 1'b1;
    end
  endtask

  // One-beat output frame from the core, accepted downstream; pops one tag.
  task automatic pop_tag(input int exp_chan);
    bus.out_ready        = 1'b1;
    bus.fft_source_valid = 1'b1;
    bus.fft_source_sop   = 1'b1;
    bus.fft_source_eop   = 1'b1;
    bus.fft_source_real  = 20'h12345 + 20'(exp_chan);
    #1;
    check("out_valid", bus.out_valid, 1);
    check("out_chan", bus.out_chan, exp_chan);
    check("out_real", bus.out_real, 32'(20'h12345 + 20'(exp_chan)));
    tick();
    bus.fft_source_valid = 1'b0;
    bus.fft_source_sop   = 1'b0;
    bus.fft_source_eop   = 1'b0;
  endtask

  initial begin
    reset_n              = 1'b0;
    bus.req_valid        = '0;
    bus.req_fftpts       = '0;
    bus.req_inverse      = '0;
    bus.fft_sink_ready   = 1'b1;
    bus.fft_source_valid = 1'b0;
    bus.fft_source_sop   = 1'b0;
    bus.fft_source_eop   = 1'b0;
    bus.fft_source_error = 2'b00;
    bus.fft_source_real  = '0;
    bus.fft_source_imag  = '0;
    bus.out_ready        = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      bus.req_real[i*DW +: DW]  = 16'(16'hA000 + i);
      bus.req_imag[i*DW +: DW]  = 16'(16'h5000 + i);
      bus.req_fftpts[i*4 +: 4]  = 4'd3;
    end
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_inflight", bus.inflight, 0);
    check("rst_fftpts", bus.fft_fftpts_in, 0);
    check("rst_inverse", bus.fft_inverse, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_sink_flags", {bus.fft_sink_valid, bus.fft_sink_sop, bus.fft_sink_eop}, 0);
    check("rst_out_chan", bus.out_chan, 0);
    check("sink_error", bus.fft_sink_error, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single channel, two back-to-back 8-point frames with one IDLE cycle between.
    bus.req_valid = 4'b0001;
    frame(0, 8, 3, 1'b0, 1'b0);
    check("single_inflight1", bus.inflight, 1);
    frame(0, 8, 3, 1'b0, 1'b0);
    check("single_inflight2", bus.inflight, 2);
    bus.req_valid = 4'b0000;
    pop_tag(0);
    pop_tag(0);
    check("single_drained", bus.inflight, 0);

    // Round-robin: rr_ptr is 1, so the order is 1, 3, then wrap to 0.
    bus.req_valid = 4'b1011;
    frame(1, 8, 3, 1'b0, 1'b0);
    frame(3, 8, 3, 1'b0, 1'b0);
    frame(0, 8, 3, 1'b0, 1'b0);
    bus.req_valid = 4'b0000;
    check("rr_inflight", bus.inflight, 3);
    pop_tag(1);
    pop_tag(3);
    pop_tag(0);

    // Random backpressure and gaps on a 16-point frame from ch2.
    bus.req_fftpts[2*4 +: 4] = 4'd4;
    bus.req_valid = 4'b0100;
    frame(2, 16, 4, 1'b0, 1'b1);
    bus.req_valid = 4'b0000;
    pop_tag(2);

    // Tag FIFO full: rr_ptr is 3, so the grants go to 0, 1, 2, 0.
    bus.req_valid = 4'b0111;
    frame(0, 8, 3, 1'b0, 1'b0);
    frame(1, 8, 3, 1'b0, 1'b0);
    frame(2, 16, 4, 1'b0, 1'b0);
    frame(0, 8, 3, 1'b0, 1'b0);
    check("full_inflight", bus.inflight, 4);
    bus.out_ready        = 1'b0;
    bus.fft_source_valid = 1'b1;
    bus.fft_source_eop   = 1'b1;
    #1;
    check("full_source_ready", bus.fft_source_ready, 0);
    check("full_out_chan", bus.out_chan, 0);
    tick();
    check("full_no_grant", bus.busy, 0);
    check("full_no_pop", bus.inflight, 4);
    pop_tag(0);
    check("full_after_pop", bus.inflight, 3);
    frame(1, 8, 3, 1'b0, 1'b0);
    check("full_refill", bus.inflight, 4);
    bus.req_valid = 4'b0000;
    pop_tag(1);
    pop_tag(2);
    pop_tag(0);
    pop_tag(1);
    check("full_drained", bus.inflight, 0);

    // Clamping: fftpts 15 becomes 10 (1024 points, inverse held), fftpts 1 becomes 3.
    bus.req_fftpts[2*4 +: 4] = 4'd15;
    bus.req_inverse[2]       = 1'b1;
    bus.req_valid            = 4'b0100;
    frame(2, 1024, 10, 1'b1, 1'b0);
    bus.req_valid = 4'b0000;
    tick();
    check("clamp_inverse_hold", bus.fft_inverse, 1);
    pop_tag(2);
    bus.req_fftpts[3*4 +: 4] = 4'd1;
    bus.req_valid            = 4'b1000;
    frame(3, 8, 3, 1'b0, 1'b0);
    bus.req_valid = 4'b0000;
    pop_tag(3);

    // Reset at sample 5 of a ch0 frame; the next frame after release comes from ch0.
    bus.req_valid = 4'b0001;
    tick();
    check("mid_busy", bus.busy, 1);
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sink", {bus.fft_sink_valid, bus.fft_sink_sop, bus.fft_sink_eop}, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_inflight", bus.inflight, 0);
    check("mid_rst_fftpts", bus.fft_fftpts_in, 0);
    tick();
    reset_n       = 1'b1;
    bus.req_valid = 4'b1011;
    frame(0, 8, 3, 1'b0, 1'b0);
    bus.req_valid = 4'b0000;
    pop_tag(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
